// File: rtl/parking_gate_if.sv
// Sensor, occupancy and counter-control signals between the gate environment and the controller.
interface parking_gate_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sensor_a;
  logic             sensor_b;
  logic [WIDTH-1:0] occupancy;
  logic             inc;
  logic             dec;
  logic             full;
  logic             empty;
  logic             seq_error;
  logic             reject;

  modport master (
    output sensor_a, sensor_b, occupancy,
    input  inc, dec, full, empty, seq_error, reject
  );

  modport slave (
    input  sensor_a, sensor_b, occupancy,
    output inc, dec, full, empty, seq_error, reject
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Decodes the two gate photo-sensors into car entry/exit pulses for the occupancy counter,
// flagging full/empty lot state and out-of-order sensor sequences.
module parking_gate_controller #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CAPACITY = 200
) (
  input logic          clk,
  input logic          reset,
  parking_gate_if.slave gate
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR} state_t;

  state_t     state;
  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic [1:0] ab;
  logic       inc_q;
  logic       dec_q;
  logic       full_q;
  logic       empty_q;
  logic       seq_error_q;
  logic       reject_q;

  assign ab = {a_sync[1], b_sync[1]};

  assign gate.inc       = inc_q;
  assign gate.dec       = dec_q;
  assign gate.full      = full_q;
  assign gate.empty     = empty_q;
  assign gate.seq_error = seq_error_q;
  assign gate.reject    = reject_q;

  // Synchronizers, lot-status flags and the sequence FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync      <= 2'b00;
      b_sync      <= 2'b00;
      state       <= IDLE;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      reject_q    <= 1'b0;
      seq_error_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      a_sync      <= {a_sync[0], gate.sensor_a};
      b_sync      <= {b_sync[0], gate.sensor_b};
      full_q      <= (gate.occupancy >= WIDTH'(CAPACITY));
      empty_q     <= (gate.occupancy == '0);
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      reject_q    <= 1'b0;
      seq_error_q <= 1'b0;

      case (state)
        IDLE: begin
          case (ab)
            2'b10: state <= EN1;
            2'b01: state <= EX1;
            2'b11: begin state <= ERR; seq_error_q <= 1'b1; end
            2'b00: state <= IDLE;
          endcase
        end
        EN1: begin
          case (ab)
            2'b11: state <= EN2;
            2'b00: state <= IDLE;
            2'b10: state <= EN1;
            2'b01: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        EN2: begin
          case (ab)
            2'b01: state <= EN3;
            2'b10: state <= EN1;
            2'b11: state <= EN2;
            2'b00: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        EN3: begin
          case (ab)
            2'b00: begin
              // Car fully inside: count it unless the lot is already full.
              state <= IDLE;
              if (full_q) reject_q <= 1'b1;
              else        inc_q    <= 1'b1;
            end
            2'b11: state <= EN2;
            2'b01: state <= EN3;
            2'b10: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        EX1: begin
          case (ab)
            2'b11: state <= EX2;
            2'b00: state <= IDLE;
            2'b01: state <= EX1;
            2'b10: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        EX2: begin
          case (ab)
            2'b10: state <= EX3;
            2'b01: state <= EX1;
            2'b11: state <= EX2;
            2'b00: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        EX3: begin
          case (ab)
            2'b00: begin
              // Car fully outside: uncount it unless the lot is already empty.
              state <= IDLE;
              if (empty_q) reject_q <= 1'b1;
              else         dec_q    <= 1'b1;
            end
            2'b11: state <= EX2;
            2'b10: state <= EX3;
            2'b01: begin state <= ERR; seq_error_q <= 1'b1; end
          endcase
        end
        ERR: begin
          if (ab == 2'b00) begin
            state <= IDLE;
          end else begin
            state       <= ERR;
            seq_error_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed and randomized bench for parking_gate_controller against a position-along-the-gate model.
module tb_parking_gate_controller;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CAPACITY = 200;
  localparam int M_IDLE = 0;
  localparam int M_CAR  = 1;
  localparam int M_ERR  = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  parking_gate_if #(.WIDTH(WIDTH)) bus ();

  parking_gate_controller #(.WIDTH(WIDTH), .CAPACITY(CAPACITY)) dut (
    .clk   (clk),
    .reset (reset),
    .gate  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int occ     = 0;
  int n_inc   = 0;
  int n_dec   = 0;
  int n_rej   = 0;

  // Model: car progress 0..3 along its travel direction; sync delay as a two-deep pipe.
  logic [1:0] m_s1 = 2'b00;
  logic [1:0] m_s2 = 2'b00;
  int m_mode = M_IDLE;
  int m_dir  = 1;
  int m_prog = 0;
  bit m_full = 1'b0;
  bit m_empty = 1'b1;
  bit e_inc, e_dec, e_rej;

  function automatic int mod4(input int x);
    return ((x % 4) + 4) % 4;
  endfunction

  // Position of the beam pattern along the outside-to-inside path.
  function automatic int pos_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (mod4(p))
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [1:0] raw, input bit rst, input int occ_v);
    int p;
    int d;
    e_inc = 1'b0;
    e_dec = 1'b0;
    e_rej = 1'b0;
    if (rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_mode = M_IDLE; m_prog = 0;
      m_full = 1'b0; m_empty = 1'b1;
      return;
    end
    p    = pos_of(m_s2);
    m_s2 = m_s1;
    m_s1 = raw;
    case (m_mode)
      M_IDLE: begin
        if (p == 1)      begin m_mode = M_CAR; m_dir = 1;  m_prog = 1; end
        else if (p == 3) begin m_mode = M_CAR; m_dir = -1; m_prog = 1; end
        else if (p == 2) m_mode = M_ERR;
      end
      M_CAR: begin
        d = mod4(m_dir * p - m_prog);
        if (d == 2) m_mode = M_ERR;
        else if (d == 1) begin
          if (m_prog == 3) begin
            m_mode = M_IDLE;
            if (m_dir == 1) begin if (m_full) e_rej = 1'b1; else e_inc = 1'b1; end
            else            begin if (m_empty) e_rej = 1'b1; else e_dec = 1'b1; end
          end else m_prog++;
        end else if (d == 3) begin
          if (m_prog == 1) m_mode = M_IDLE;
          else m_prog--;
        end
      end
      default: if (p == 0) m_mode = M_IDLE;
    endcase
    m_full  = (occ_v >= int'(CAPACITY));
    m_empty = (occ_v == 0);
  endtask

  task automatic tick(input logic [1:0] raw, input bit rst);
    @(negedge clk);
    bus.sensor_a  = raw[1];
    bus.sensor_b  = raw[0];
    bus.occupancy = WIDTH'(occ);
    reset         = rst;
    @(posedge clk);
    model_edge(raw, rst, occ);
    #1;
    check("inc",       32'(bus.inc),       32'(e_inc));
    check("dec",       32'(bus.dec),       32'(e_dec));
    check("reject",    32'(bus.reject),    32'(e_rej));
    check("seq_error", 32'(bus.seq_error), 32'(m_mode == M_ERR));
    check("full",      32'(bus.full),      32'(m_full));
    check("empty",     32'(bus.empty),     32'(m_empty));
    check("inc_dec_excl", 32'(bus.inc & bus.dec), 32'd0);
    n_inc += int'(bus.inc);
    n_dec += int'(bus.dec);
    n_rej += int'(bus.reject);
    if (!rst) occ = occ + int'(e_inc) - int'(e_dec);
    if (occ > 255) occ = 255;
    if (occ < 0)   occ = 0;
  endtask

  task automatic hold(input logic [1:0] raw, input int n);
    repeat (n) tick(raw, 1'b0);
  endtask

  task automatic clear_counts();
    n_inc = 0; n_dec = 0; n_rej = 0;
  endtask

  task automatic entry_seq();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
  endtask

  task automatic exit_seq();
    hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 4);
  endtask

  task automatic set_occ(input int v);
    occ = v;
    hold(2'b00, 2);
  endtask

  int gp;
  int gdir;
  int r;

  initial begin
    reset         = 1'b1;
    bus.sensor_a  = 1'b0;
    bus.sensor_b  = 1'b0;
    bus.occupancy = '0;

    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_full",  32'(bus.full),  32'd0);

    // Plain entry and exit.
    set_occ(5); clear_counts(); entry_seq();
    check("entry_inc_count", 32'(n_inc), 32'd1);
    check("entry_rej_count", 32'(n_rej), 32'd0);
    set_occ(5); clear_counts(); exit_seq();
    check("exit_dec_count", 32'(n_dec), 32'd1);
    set_occ(0); clear_counts(); exit_seq();
    check("exit_empty_dec", 32'(n_dec), 32'd0);
    check("exit_empty_rej", 32'(n_rej), 32'd1);

    // Capacity boundary.
    set_occ(200); clear_counts(); entry_seq();
    check("full_inc", 32'(n_inc), 32'd0);
    check("full_rej", 32'(n_rej), 32'd1);
    set_occ(199); clear_counts(); entry_seq();
    check("below_full_inc", 32'(n_inc), 32'd1);

    // Back-out then a valid entry.
    set_occ(10); clear_counts();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 4);
    check("backout_pulses", 32'(n_inc + n_dec + n_rej), 32'd0);
    entry_seq();
    check("after_backout_inc", 32'(n_inc), 32'd1);

    // Error entry, persistence and recovery.
    clear_counts();
    hold(2'b11, 4); hold(2'b01, 4); hold(2'b10, 4); hold(2'b00, 4);
    check("err_pulses", 32'(n_inc + n_dec + n_rej), 32'd0);
    check("err_cleared", 32'(bus.seq_error), 32'd0);

    // Reset in EN3 abandons the car.
    clear_counts();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
    tick(2'b00, 1'b1);
    hold(2'b00, 4);
    check("reset_mid_inc", 32'(n_inc), 32'd0);
    entry_seq();
    check("after_reset_inc", 32'(n_inc), 32'd1);

    // Randomized walks along the sensor path with occasional jumps, resets and occupancy changes.
    gp   = 0;
    gdir = 1;
    for (int ph = 0; ph < 300; ph++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0:       occ = 0;
          1:       occ = 1;
          2:       occ = 199;
          3:       occ = 200;
          4:       occ = 255;
          default: occ = int'($urandom_range(0, 255));
        endcase
      end
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        tick(ab_of(gp), 1'b1);
      end else begin
        if (r < 70)      gp = mod4(gp + gdir);
        else if (r < 85) gp = mod4(gp - gdir);
        else if (r < 93) gp = mod4(gp + 2);
        if (gp == 0 && $urandom_range(0, 1) == 1) gdir = -gdir;
        hold(ab_of(gp), int'($urandom_range(1, 5)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
Sequences the parking-lot occupancy counter from two photo-sensors at the gate. Sensor a is on the outer side and sensor b is on the inner side. The block synchronizes the sensors and decodes the ordered blocking pattern into completed car entries and exits. It issues one-cycle inc/dec pulses to the counter and flags full, empty and sensor-sequence errors. It sits between the gate sensors and the counter; it reads back the counter's occupancy.

Parameters:
WIDTH, 8, width of occupancy bus; matches counter.
CAPACITY, 200, lot size; full when occupancy >= CAPACITY; must be < 2**WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sensor_a  input  1  outer sensor, 1 = beam blocked; asynchronous to clk
sensor_b  input  1  inner sensor, 1 = beam blocked; asynchronous to clk
occupancy  input  WIDTH  current count from counter
inc  output  1  one-cycle pulse: car entered; drives counter inc
dec  output  1  one-cycle pulse: car exited; drives counter dec
full  output  1  registered, occupancy >= CAPACITY
empty  output  1  registered, occupancy == 0
seq_error  output  1  high while FSM is in ERR
reject  output  1  one-cycle pulse: entry completed while full, or exit completed while empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset state:
  - Sync flops cleared to 0; FSM to IDLE.
  - inc=0, dec=0, reject=0, seq_error=0, full=0, empty=1.
  - Reset mid-sequence abandons the car in progress; no pulse is issued.
- Synchronizer:
  - Two-flop chain per sensor. The FSM sees ab = {a_s2, b_s2}.
  - A raw change appears at the FSM on the 2nd edge. Registered outputs respond on the 3rd edge.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR. Transitions by ab value:
  - IDLE: 10->EN1; 01->EX1; 00 stay; 11->ERR.
  - EN1: 11->EN2; 00->IDLE (car backed out, no count); 10 stay; 01->ERR.
  - EN2: 01->EN3; 10->EN1; 11 stay; 00->ERR.
  - EN3: 00->IDLE and entry-complete; 11->EN2; 01 stay; 10->ERR.
  - EX1/EX2/EX3: mirror of EN1/EN2/EN3 with a and b swapped; EX3 on 00 -> IDLE and exit-complete.
  - ERR: seq_error=1; stay until ab=00, then ->IDLE. No pulses are issued in or leaving ERR.
- Entry-complete:
  - If full=0: inc=1 for exactly one cycle.
  - If full=1: inc stays 0 and reject=1 for one cycle.
- Exit-complete:
  - If empty=0: dec=1 for one cycle.
  - If empty=1: dec stays 0 and reject=1 for one cycle.
- inc and dec are never high in the same cycle; they come from mutually exclusive paths.
- full and empty are registered from occupancy with 1-cycle lag. A complete sequence takes at least 4 cycles after the previous pulse, so the lag is never stale at decision time.
- Width: occupancy compare is unsigned, WIDTH bits. The block never produces inc at CAPACITY or dec at 0, so the counter never wraps.
- Both sensors toggling in the same cycle (a double jump such as 10->01) is handled by the table above (->ERR).

Test Plan:
- Entry: reset; occupancy=5; drive ab 10,11,01,00, each held 4 cycles -> single inc pulse on the 3rd edge after ab=00; dec=0, reject=0, seq_error=0.
- Exit: occupancy=5; ab 01,11,10,00 -> single dec pulse; then occupancy=0 and repeat -> no dec, reject pulse, empty=1.
- Full: occupancy=200 (CAPACITY) -> full=1 after 1 cycle; full entry sequence -> inc=0, reject=1 for one cycle. occupancy=199 -> inc=1.
- Back-out: ab 10,11,10,00 -> no inc/dec/reject; FSM returns to IDLE; a following valid entry still produces inc.
- Error: from IDLE, ab=11 -> seq_error=1 three edges later; ab 01,10 keep ERR; ab=00 -> seq_error=0; no pulses throughout.
- Reset mid-operation: reach EN3 (ab=01), assert reset 1 cycle, release with ab=00 -> no inc; outputs at reset values; next full entry counts normally.
